semafor_monitor: RTL and testbench
==================================

# semafor_monitor

Safety monitor and lamp gate for the five lamp outputs of the traffic-light controller (`r_m`, `v_m`, `g_m`, `r_p`, `v_p`). It sits between the controller and the lamp drivers and checks every sampled lamp combination, every phase transition and every phase dwell time. Legal lamps pass through with fixed latency. On the first violation it latches a fault code and forces the car lamps to flashing yellow with all pedestrian lamps off, until an explicit clear or reset.

## Interface
- `CNT_W`, 7: width of dwell and timeout counters; counters saturate at 2^CNT_W-1.
- `VM_MIN`, 50: minimum cycles in phase VM_RP before it may be left.
- `GM_MIN`, 5: minimum cycles in phase GM_RP.
- `GM_MAX`, 8: maximum cycles in phase GM_RP.
- `VP_MIN`, 25: minimum cycles in phase RM_VP.
- `DARK_MAX`, 32: maximum cycles of all-dark after reset or clear.
- `FLASH_HALF`, 8: half-period, in cycles, of the fault flash.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active low.
- `r_m`, `v_m`, `g_m`, `r_p`, `v_p` in 1 each: lamp outputs from the controller.
- `clr` in 1: synchronous fault clear.
- `out_r_m`, `out_v_m`, `out_g_m`, `out_r_p`, `out_v_p` out 1 each: gated lamp drives.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: cause of the first fault; 0 means none.
- `phase` out 2: accepted phase. 0 DARK, 1 VM_RP, 2 GM_RP, 3 RM_VP.

## Operation
- **Input stage.** Inputs are registered into sample regs `s_*` every cycle, including during a fault. All checks operate on `s_*`.
- **Phase classification of `s_*`.**
  - All zero: DARK.
  - `v_m & r_p` only: VM_RP.
  - `g_m & r_p` only: GM_RP.
  - `r_m & v_p` only: RM_VP.
  - Anything else: ILLEGAL.
- **Legal transitions.**
  - DARK→VM_RP, VM_RP→GM_RP, GM_RP→RM_VP, RM_VP→VM_RP.
  - Remaining in the same phase is legal.
  - DARK is legal only while `phase`=DARK.
- **Dwell counter.** Loaded with 1 when a phase is entered. Increments on each further sample of the same phase, saturating.
- **Fault codes.** Evaluated each cycle while `fault`=0. When several conditions hit in the same cycle, the lowest code wins.
  - 1: ILLEGAL combination, or DARK while `phase`≠DARK.
  - 2: illegal transition.
  - 3: a phase is left with dwell < its MIN (VM_MIN, GM_MIN or VP_MIN).
  - 4: GM_RP sampled for the (GM_MAX+1)-th consecutive cycle.
  - 5: DARK sampled for the (DARK_MAX+1)-th consecutive cycle.
- **On a fault.**
  - `fault`<=1 and `fault_code`<=code.
  - `phase` is frozen.
  - Further checks are ignored, so `fault_code` always holds the first fault.
- **Normal output gating.** While `fault`=0 and the current `s_*` is legal, `out_*`<=`s_*` and `phase` is updated. An offending sample never reaches `out_*`.
- **Fault output.**
  - All `out_*`=0 except `out_g_m`.
  - `out_g_m`=1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, repeating.
  - The flash counter starts at the fault edge with `out_g_m`=1.
- **Clear.** `clr`=1 has priority over every check in its cycle.
  - `fault`<=0, `fault_code`<=0, `phase`<=DARK.
  - Dwell and dark counters <=0.
  - All `out_*`<=0.
  - Monitoring resumes on the next cycle.
  - `clr` while `fault`=0 performs the same resynchronisation.
- **Reset values.** All `out_*`=0, `fault`=0, `fault_code`=0, `phase`=0, all counters 0.

## Timing
- **Latency.** Lamp value present before edge k is sampled at edge k and appears on `out_*` after edge k+1. Latency is 2 cycles.
- **Fault timing.** `fault` rises after the same edge k+1. The first flash cycle is therefore coincident with the suppressed sample.
- **Dwell accounting.** A phase held for N consecutive samples exits with dwell=N. The MIN check is dwell<MIN, so exactly MIN cycles is legal.
- **Simultaneous events.**
  - `clr` together with a violating sample: `clr` wins and the sample is discarded.
  - That sample is not used as a transition source.
- **Asynchronous reset mid-fault.** The fault is cleared immediately and the flash stops.

## Test plan
- **Normal cycle.** Reset, then drive DARK 3, VM_RP 60, GM_RP 6, RM_VP 30, VM_RP 60 cycles -> `out_*` equals the input delayed by 2 cycles; `fault`=0; `phase` follows 0,1,2,3,1.
- **Illegal combination.** `v_m`=1 and `v_p`=1 together during VM_RP -> `fault`=1, `fault_code`=1. The combination never appears on `out_*`. `out_g_m` toggles every 8 cycles, starting at 1.
- **Short dwell.** VM_RP 20 cycles, then GM_RP -> `fault_code`=3. With VM_MIN=50, VM_RP held exactly 50 cycles -> no fault.
- **Illegal transitions and yellow overrun.**
  - VM_RP→RM_VP directly -> `fault_code`=2.
  - GM_RP held 9 cycles -> `fault_code`=4 on the 9th sample; 8 cycles -> no fault.
- **Dark timeout and first-fault latching.** Hold DARK 33 cycles after reset -> `fault_code`=5. Then apply an illegal combination -> `fault_code` stays 5.
- **Clear and reset.**
  - `clr` pulse during a fault with a simultaneous illegal sample -> `fault`=0 and `phase`=0 next cycle.
  - A VM_RP sequence is then accepted.
  - `rst_n` low mid-flash -> all outputs 0 immediately.

Source files
------------

// File: rtl/semafor_monitor.sv
// Safety monitor and lamp gate between the traffic-light controller and the lamp drivers.
// Passes legal lamp combinations through with two cycles of latency and latches the first fault.
module semafor_monitor #(
  parameter int CNT_W      = 7,
  parameter int VM_MIN     = 50,
  parameter int GM_MIN     = 5,
  parameter int GM_MAX     = 8,
  parameter int VP_MIN     = 25,
  parameter int DARK_MAX   = 32,
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r_m,
  input  logic       v_m,
  input  logic       g_m,
  input  logic       r_p,
  input  logic       v_p,
  input  logic       clr,
  output logic       out_r_m,
  output logic       out_v_m,
  output logic       out_g_m,
  output logic       out_r_p,
  output logic       out_v_p,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    PH_DARK  = 2'd0,
    PH_VM_RP = 2'd1,
    PH_GM_RP = 2'd2,
    PH_RM_VP = 2'd3
  } phase_t;

  logic             s_r_m, s_v_m, s_g_m, s_r_p, s_v_p;
  logic             s_vld;
  logic [4:0]       s_lamps;
  phase_t           ph_q;
  phase_t           cls;
  logic             cls_ok;
  logic             trans_ok;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] dark_cnt;
  logic [CNT_W-1:0] flash_cnt;
  logic [CNT_W-1:0] min_dwell;
  logic [2:0]       code;

  assign s_lamps = {s_r_m, s_v_m, s_g_m, s_r_p, s_v_p};
  assign phase   = ph_q;

  always_comb begin
    cls    = PH_DARK;
    cls_ok = 1'b1;
    case (s_lamps)
      5'b00000: cls = PH_DARK;
      5'b01010: cls = PH_VM_RP;
      5'b00110: cls = PH_GM_RP;
      5'b10001: cls = PH_RM_VP;
      default:  cls_ok = 1'b0;
    endcase

    case (ph_q)
      PH_VM_RP: min_dwell = CNT_W'(VM_MIN);
      PH_GM_RP: min_dwell = CNT_W'(GM_MIN);
      PH_RM_VP: min_dwell = CNT_W'(VP_MIN);
      default:  min_dwell = '0;
    endcase

    trans_ok = (cls == ph_q)
            || (ph_q == PH_DARK  && cls == PH_VM_RP)
            || (ph_q == PH_VM_RP && cls == PH_GM_RP)
            || (ph_q == PH_GM_RP && cls == PH_RM_VP)
            || (ph_q == PH_RM_VP && cls == PH_VM_RP);

    // Priority chain: the lowest code wins when several checks hit together.
    code = 3'd0;
    if (!cls_ok || (cls == PH_DARK && ph_q != PH_DARK))
      code = 3'd1;
    else if (!trans_ok)
      code = 3'd2;
    else if (cls != ph_q && ph_q != PH_DARK && dwell < min_dwell)
      code = 3'd3;
    else if (cls == PH_GM_RP && ph_q == PH_GM_RP && dwell >= CNT_W'(GM_MAX))
      code = 3'd4;
    else if (cls == PH_DARK && ph_q == PH_DARK && dark_cnt >= CNT_W'(DARK_MAX))
      code = 3'd5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s_r_m, s_v_m, s_g_m, s_r_p, s_v_p}                 <= '0;
      s_vld                                               <= 1'b0;
      {out_r_m, out_v_m, out_g_m, out_r_p, out_v_p}       <= '0;
      fault                                               <= 1'b0;
      fault_code                                          <= '0;
      ph_q                                                <= PH_DARK;
      dwell                                               <= '0;
      dark_cnt                                            <= '0;
      flash_cnt                                           <= '0;
    end else begin
      {s_r_m, s_v_m, s_g_m, s_r_p, s_v_p} <= {r_m, v_m, g_m, r_p, v_p};
      s_vld                               <= 1'b1;

      if (clr) begin
        {out_r_m, out_v_m, out_g_m, out_r_p, out_v_p} <= '0;
        fault      <= 1'b0;
        fault_code <= '0;
        ph_q       <= PH_DARK;
        dwell      <= '0;
        dark_cnt   <= '0;
        flash_cnt  <= '0;
      end else if (fault) begin
        if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
          flash_cnt <= '0;
          out_g_m   <= ~out_g_m;
        end else begin
          flash_cnt <= flash_cnt + 1'b1;
        end
      end else if (s_vld) begin
        // s_vld keeps the reset value of the sample regs from counting as a dark sample.
        if (code != 3'd0) begin
          fault      <= 1'b1;
          fault_code <= code;
          {out_r_m, out_v_m, out_g_m, out_r_p, out_v_p} <= 5'b00100;
          flash_cnt  <= '0;
        end else begin
          {out_r_m, out_v_m, out_g_m, out_r_p, out_v_p} <= s_lamps;
          ph_q <= cls;
          if (cls == ph_q) begin
            if (dwell != '1) dwell <= dwell + 1'b1;
          end else begin
            dwell <= CNT_W'(1);
          end
          if (cls == PH_DARK) begin
            if (dark_cnt != '1) dark_cnt <= dark_cnt + 1'b1;
          end else begin
            dark_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_semafor_monitor.sv
// Directed bench for semafor_monitor: normal cycle, each fault code, flash pattern, clear and reset.
module tb_semafor_monitor;

  localparam logic [4:0] DARK = 5'b00000;
  localparam logic [4:0] VM   = 5'b01010;
  localparam logic [4:0] GM   = 5'b00110;
  localparam logic [4:0] RM   = 5'b10001;
  localparam logic [4:0] BAD  = 5'b01011;
  localparam logic [4:0] FLSH = 5'b00100;

  logic       clk = 1'b0;
  logic       rst_n, clr;
  logic       r_m, v_m, g_m, r_p, v_p;
  logic       out_r_m, out_v_m, out_g_m, out_r_p, out_v_p;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic [4:0] outv;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [4:0]  d1;
  logic [1:0]  p1;

  assign outv = {out_r_m, out_v_m, out_g_m, out_r_p, out_v_p};

  always #5 clk = ~clk;

  semafor_monitor #(
    .CNT_W(7), .VM_MIN(50), .GM_MIN(5), .GM_MAX(8),
    .VP_MIN(25), .DARK_MAX(32), .FLASH_HALF(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r_m(r_m), .v_m(v_m), .g_m(g_m), .r_p(r_p), .v_p(v_p),
    .clr(clr),
    .out_r_m(out_r_m), .out_v_m(out_v_m), .out_g_m(out_g_m),
    .out_r_p(out_r_p), .out_v_p(out_v_p),
    .fault(fault), .fault_code(fault_code), .phase(phase)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {r_m, v_m, g_m, r_p, v_p} = v;
    @(posedge clk);
    #1;
  endtask

  // Legal run: output trails the driven lamps by one step here (two cycles from input).
  task automatic run(input logic [4:0] v, input int n, input logic [1:0] ph);
    for (int i = 0; i < n; i++) begin
      drive(v);
      chk("run_out", {3'b0, outv}, {3'b0, d1});
      chk("run_phase", {6'b0, phase}, {6'b0, p1});
      chk("run_fault", {7'b0, fault}, 8'd0);
      d1 = v;
      p1 = ph;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    drive(DARK);
    clr = 1'b0;
    d1 = DARK;
    p1 = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    {r_m, v_m, g_m, r_p, v_p} = DARK;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {3'b0, outv}, 8'd0);
    chk("rst_fault", {7'b0, fault}, 8'd0);
    chk("rst_code", {5'b0, fault_code}, 8'd0);
    chk("rst_phase", {6'b0, phase}, 8'd0);
    rst_n = 1'b1;
    d1 = DARK;
    p1 = 2'd0;

    // Normal cycle plus exact-minimum and GM_MAX boundaries
    run(DARK, 3, 2'd0);
    run(VM, 60, 2'd1);
    run(GM, 6, 2'd2);
    run(RM, 30, 2'd3);
    run(VM, 60, 2'd1);
    run(GM, 8, 2'd2);
    run(RM, 25, 2'd3);
    run(VM, 10, 2'd1);

    // Illegal combination
    drive(BAD);
    chk("ill_prev_out", {3'b0, outv}, {3'b0, VM});
    drive(VM);
    chk("ill_fault", {7'b0, fault}, 8'd1);
    chk("ill_code", {5'b0, fault_code}, 8'd1);
    chk("ill_out", {3'b0, outv}, {3'b0, FLSH});
    chk("ill_phase", {6'b0, phase}, 8'd1);
    for (int j = 1; j < 24; j++) begin
      drive(VM);
      chk("flash", {3'b0, outv}, (((j / 8) % 2) == 0) ? {3'b0, FLSH} : 8'd0);
    end

    // Clear with an illegal sample pending
    drive(BAD);
    chk("ill_code_hold", {5'b0, fault_code}, 8'd1);
    do_clr();
    chk("clr_fault", {7'b0, fault}, 8'd0);
    chk("clr_code", {5'b0, fault_code}, 8'd0);
    chk("clr_phase", {6'b0, phase}, 8'd0);
    chk("clr_out", {3'b0, outv}, 8'd0);
    run(VM, 55, 2'd1);

    // Short VM dwell
    do_clr();
    run(VM, 20, 2'd1);
    drive(GM);
    chk("short_prev_out", {3'b0, outv}, {3'b0, VM});
    drive(GM);
    chk("short_fault", {7'b0, fault}, 8'd1);
    chk("short_code", {5'b0, fault_code}, 8'd3);
    chk("short_out", {3'b0, outv}, {3'b0, FLSH});
    chk("short_phase", {6'b0, phase}, 8'd1);

    // Direct VM_RP -> RM_VP
    do_clr();
    run(VM, 55, 2'd1);
    drive(RM);
    drive(RM);
    chk("trans_code", {5'b0, fault_code}, 8'd2);
    chk("trans_phase", {6'b0, phase}, 8'd1);

    // Yellow overrun after exactly VM_MIN
    do_clr();
    run(VM, 50, 2'd1);
    run(GM, 9, 2'd2);
    drive(GM);
    chk("ovr_fault", {7'b0, fault}, 8'd1);
    chk("ovr_code", {5'b0, fault_code}, 8'd4);
    chk("ovr_phase", {6'b0, phase}, 8'd2);
    chk("ovr_out", {3'b0, outv}, {3'b0, FLSH});

    // Asynchronous reset mid-flash
    repeat (3) drive(GM);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", {3'b0, outv}, 8'd0);
    chk("arst_fault", {7'b0, fault}, 8'd0);
    chk("arst_code", {5'b0, fault_code}, 8'd0);
    chk("arst_phase", {6'b0, phase}, 8'd0);
    {r_m, v_m, g_m, r_p, v_p} = DARK;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Dark timeout, then first fault must stick
    repeat (33) drive(DARK);
    chk("dark_ok_fault", {7'b0, fault}, 8'd0);
    drive(DARK);
    chk("dark_fault", {7'b0, fault}, 8'd1);
    chk("dark_code", {5'b0, fault_code}, 8'd5);
    chk("dark_out", {3'b0, outv}, {3'b0, FLSH});
    chk("dark_phase", {6'b0, phase}, 8'd0);
    repeat (3) drive(BAD);
    chk("first_fault_code", {5'b0, fault_code}, 8'd5);
    chk("first_fault_flag", {7'b0, fault}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
